conv_ofmap_writer: RTL

Write-side address generator for a convolution layer's output feature map memory. It accepts the raster-ordered result stream from the conv/accumulate datapath and buffers each beat in a single output register. It generates the linear write address for every output pixel across all output maps computed by one multiplier, and issues single-word writes with a valid/ready handshake toward the memory arbiter. It is the write-direction counterpart of the input-feature read address generator and walks the same ordering: column innermost, then row, then output map.

---
 rtl/conv_ofmap_writer_if.sv | 24 ++
 rtl/conv_ofmap_writer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/conv_ofmap_writer_if.sv
// Result-stream input and memory write request bundle for conv_ofmap_writer.
// master: the writer block itself; slave: the datapath/arbiter side.
interface conv_ofmap_writer_if #(
  parameter int DATA_WIDTH     = 16,
  parameter int OUT_ADDR_WIDTH = 12
);
  logic                      in_valid;
  logic                      in_ready;
  logic [DATA_WIDTH-1:0]     in_data;
  logic                      wr_en;
  logic                      wr_ready;
  logic [OUT_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;

  modport master (
    input  in_valid, in_data, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_valid, in_data, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/conv_ofmap_writer.sv
// Output feature map write address generator: takes the raster-ordered
// result stream (col, then row, then map) and issues one registered
// single-word write per pixel toward the memory arbiter.
module conv_ofmap_writer #(
  parameter int OUT_FEATURE_WIDTH = 32,
  parameter int NUM_ONEMULT       = 1,
  parameter int DATA_WIDTH        = 16,
  parameter int OUT_ADDR_WIDTH    = 12,
  parameter int BASE_ADDR         = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  conv_ofmap_writer_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int W  = OUT_FEATURE_WIDTH;
  localparam int M  = NUM_ONEMULT;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int AW = OUT_ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [CW-1:0]         row_q, row_d;
  logic [MW-1:0]         map_q, map_d;
  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;

  logic          in_ready;
  logic          accept;
  logic          wr_fire;
  logic          last_col, last_row, last_map;
  logic [AW-1:0] lin_addr;

  assign last_col = (col_q == CW'(W - 1));
  assign last_row = (row_q == CW'(W - 1));
  assign last_map = (map_q == MW'(M - 1));

  // Address arithmetic is done modulo 2^AW per term, which equals the
  // full-width sum truncated to AW bits.
  assign lin_addr = AW'(BASE_ADDR) + AW'(map_q) * AW'(W * W)
                  + AW'(row_q) * AW'(W) + AW'(col_q);

  assign in_ready = (state_q == RUN) && (!wr_en_q || bus.wr_ready);
  assign accept   = bus.in_valid && in_ready;
  assign wr_fire  = wr_en_q && bus.wr_ready;

  // Next-state, counter advance and output register load
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    map_d     = map_q;
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;

    if (wr_fire) begin
      wr_en_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          col_d   = '0;
          row_d   = '0;
          map_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_addr_d = lin_addr;
          wr_data_d = bus.in_data;
          if (last_col && last_row && last_map) begin
            state_d = DRAIN;
          end else if (!last_col) begin
            col_d = col_q + CW'(1);
          end else begin
            col_d = '0;
            if (!last_row) begin
              row_d = row_q + CW'(1);
            end else begin
              row_d = '0;
              map_d = map_q + MW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (!wr_en_q || bus.wr_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and output register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      map_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      map_q     <= map_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

endmodule
